// File: rtl/orb_desc_pkg.sv
// Shared constants and the order-entry type for the ORB descriptor retirement path.
package orb_desc_pkg;
  localparam int NUM_ENGINES = 4;
  localparam int DESC_W      = 256;
  localparam int ENG_W       = $clog2(NUM_ENGINES);

  typedef struct packed {
    logic             drop;
    logic [ENG_W-1:0] engine;
  } order_entry_t;
endpackage

// File: rtl/descriptor_order_fifo.sv
// Synchronous order FIFO with registered count, full and empty flags.
module descriptor_order_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             push_ok, pop_ok;

  assign push_ok = push & ~full_reg;
  assign pop_ok  = pop & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) count_next = count_reg + CNT_W'(1);
    else if (pop_ok && !push_ok) count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  // Head is read combinationally so a new entry is visible the cycle after its push.
  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
endmodule

// File: rtl/descriptor_retire_arbiter.sv
// Retires engine descriptors in dispatch order, inserting zero placeholders for drops.
// Optional RETIRE_ARB_STATS_EN adds saturating descriptor/drop handshake counters.
module descriptor_retire_arbiter
  import orb_desc_pkg::*;
#(
  parameter int ORDER_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dispatch_valid,
  input  logic [ENG_W-1:0]              dispatch_engine,
  input  logic                          dispatch_drop,
  output logic                          order_full,
  input  logic [NUM_ENGINES-1:0]        eng_done,
  input  logic [NUM_ENGINES*DESC_W-1:0] eng_desc,
  output logic [NUM_ENGINES-1:0]        eng_release,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DESC_W-1:0]             out_desc,
  output logic                          out_dropped,
`ifdef RETIRE_ARB_STATS_EN
  output logic [15:0]                   stat_desc_cnt,
  output logic [15:0]                   stat_drop_cnt,
`endif
  output logic                          err_overflow
);
  localparam int ENTRY_W = $bits(order_entry_t);
  localparam int CNT_W   = $clog2(ORDER_DEPTH) + 1;

  order_entry_t             push_entry, head_entry;
  logic [ENTRY_W-1:0]       head_bits;
  logic [CNT_W-1:0]         order_count;
  logic                     fifo_full, fifo_empty;
  logic                     load;
  logic                     head_slot_valid;
  logic [DESC_W-1:0]        head_slot_desc;
  logic [NUM_ENGINES-1:0]   unload, collide;
  logic                     slot_valid_reg [NUM_ENGINES];
  logic [DESC_W-1:0]        slot_desc_reg  [NUM_ENGINES];
  logic                     out_valid_reg, out_dropped_reg, err_reg;
  logic [DESC_W-1:0]        out_desc_reg;
  logic [NUM_ENGINES-1:0]   release_reg;

  always_comb begin
    push_entry.drop   = dispatch_drop;
    push_entry.engine = dispatch_drop ? '0 : dispatch_engine;
  end

  descriptor_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_order_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (dispatch_valid),
    .push_data (push_entry),
    .pop       (load),
    .pop_data  (head_bits),
    .count     (order_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_entry = order_entry_t'(head_bits);

  always_comb begin
    head_slot_valid = 1'b0;
    head_slot_desc  = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      if (head_entry.engine == ENG_W'(e)) begin
        head_slot_valid = slot_valid_reg[e];
        head_slot_desc  = slot_desc_reg[e];
      end
    end
  end

  // A head whose slot is still empty stalls everything behind it.
  assign load = ~fifo_empty & (~out_valid_reg | out_ready) &
                (head_entry.drop | head_slot_valid);

  generate
    for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_slot
      assign unload[gi]  = load & ~head_entry.drop & (head_entry.engine == ENG_W'(gi));
      assign collide[gi] = eng_done[gi] & slot_valid_reg[gi] & ~unload[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_valid_reg[gi] <= 1'b0;
          slot_desc_reg[gi]  <= '0;
        end else if (eng_done[gi]) begin
          // Capture-during-unload keeps the slot full with the fresh result.
          if (!slot_valid_reg[gi] || unload[gi]) begin
            slot_valid_reg[gi] <= 1'b1;
            slot_desc_reg[gi]  <= eng_desc[gi*DESC_W +: DESC_W];
          end
        end else if (unload[gi]) begin
          slot_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg   <= 1'b0;
      out_desc_reg    <= '0;
      out_dropped_reg <= 1'b0;
      release_reg     <= '0;
      err_reg         <= 1'b0;
    end else begin
      release_reg <= unload;
      if (load) begin
        out_valid_reg   <= 1'b1;
        out_desc_reg    <= head_entry.drop ? '0 : head_slot_desc;
        out_dropped_reg <= head_entry.drop;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if ((dispatch_valid && order_count == CNT_W'(ORDER_DEPTH)) || (|collide))
        err_reg <= 1'b1;
    end
  end

`ifdef RETIRE_ARB_STATS_EN
  logic [15:0] desc_cnt_reg, drop_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_cnt_reg <= '0;
      drop_cnt_reg <= '0;
    end else if (out_valid_reg && out_ready) begin
      if (out_dropped_reg) begin
        if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end else begin
        if (desc_cnt_reg != 16'hFFFF) desc_cnt_reg <= desc_cnt_reg + 16'd1;
      end
    end
  end

  assign stat_desc_cnt = desc_cnt_reg;
  assign stat_drop_cnt = drop_cnt_reg;
`endif

  assign order_full   = fifo_full;
  assign eng_release  = release_reg;
  assign out_valid    = out_valid_reg;
  assign out_desc     = out_desc_reg;
  assign out_dropped  = out_dropped_reg;
  assign err_overflow = err_reg;
endmodule

// File: tb/tb_descriptor_retire_arbiter.sv
// Directed bench for descriptor_retire_arbiter: ordering, drops, backpressure, overflow, reset.
module tb_descriptor_retire_arbiter;
  localparam int NE = 4;
  localparam int DW = 256;

  logic            clk;
  logic            rst_n;
  logic            dispatch_valid;
  logic [1:0]      dispatch_engine;
  logic            dispatch_drop;
  logic            order_full;
  logic [NE-1:0]   eng_done;
  logic [NE*DW-1:0] eng_desc;
  logic [NE-1:0]   eng_release;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_desc;
  logic            out_dropped;
  logic            err_overflow;
`ifdef RETIRE_ARB_STATS_EN
  logic [15:0]     stat_desc_cnt;
  logic [15:0]     stat_drop_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  descriptor_retire_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dispatch_valid  (dispatch_valid),
    .dispatch_engine (dispatch_engine),
    .dispatch_drop   (dispatch_drop),
    .order_full      (order_full),
    .eng_done        (eng_done),
    .eng_desc        (eng_desc),
    .eng_release     (eng_release),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_desc        (out_desc),
    .out_dropped     (out_dropped),
`ifdef RETIRE_ARB_STATS_EN
    .stat_desc_cnt   (stat_desc_cnt),
    .stat_drop_cnt   (stat_drop_cnt),
`endif
    .err_overflow    (err_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input int eng, input logic drop);
    dispatch_valid  = 1'b1;
    dispatch_engine = 2'(eng);
    dispatch_drop   = drop;
    tick();
    dispatch_valid  = 1'b0;
    dispatch_drop   = 1'b0;
  endtask

  task automatic set_desc(input int eng, input logic [DW-1:0] val);
    eng_desc[eng*DW +: DW] = val;
  endtask

  task automatic expect_out(input string tag, input logic [DW-1:0] desc,
                            input logic dropped, input logic [NE-1:0] rel);
    chk({tag, "_valid"}, DW'(out_valid), DW'(1));
    chk({tag, "_desc"}, out_desc, desc);
    chk({tag, "_dropped"}, DW'(out_dropped), DW'(dropped));
    chk({tag, "_release"}, DW'(eng_release), DW'(rel));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, DW'(out_valid), DW'(0));
    chk({tag, "_release"}, DW'(eng_release), DW'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_engine = '0;
    dispatch_drop = 1'b0;
    eng_done = '0;
    eng_desc = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_desc", out_desc, '0);
    chk("rst_dropped", DW'(out_dropped), DW'(0));
    chk("rst_release", DW'(eng_release), DW'(0));
    chk("rst_err", DW'(err_overflow), DW'(0));
    chk("rst_full", DW'(order_full), DW'(0));
    rst_n = 1'b1;
    tick();

    // Two done pulses in one cycle
    dispatch(0, 1'b0);
    dispatch(1, 1'b0);
    set_desc(0, DW'('hA));
    set_desc(1, DW'('hB));
    eng_done = 4'b0011;
    tick();
    eng_done = '0;
    expect_idle("dual_wait");
    tick();
    expect_out("dual_a", DW'('hA), 1'b0, 4'b0001);
    tick();
    expect_out("dual_b", DW'('hB), 1'b0, 4'b0010);
    tick();
    expect_idle("dual_end");
    $display("txn dual-done complete");

    // Out-of-order completion: e0 done early, held until e2 retires
    dispatch(2, 1'b0);
    dispatch(0, 1'b0);
    set_desc(0, DW'('hC0));
    eng_done = 4'b0001;
    tick();
    eng_done = '0;
    for (int i = 0; i < 4; i++) begin
      expect_idle("ooo_hold");
      tick();
    end
    set_desc(2, DW'('hC2));
    eng_done = 4'b0100;
    tick();
    eng_done = '0;
    expect_idle("ooo_wait");
    tick();
    expect_out("ooo_e2", DW'('hC2), 1'b0, 4'b0100);
    tick();
    expect_out("ooo_e0", DW'('hC0), 1'b0, 4'b0001);
    tick();
    expect_idle("ooo_end");
    $display("txn out-of-order complete");

    // Drop insertion
    dispatch(1, 1'b0);
    dispatch(1, 1'b1);
    dispatch(3, 1'b0);
    set_desc(1, DW'('hD1));
    set_desc(3, DW'('hD3));
    eng_done = 4'b1010;
    tick();
    eng_done = '0;
    tick();
    expect_out("drop_d1", DW'('hD1), 1'b0, 4'b0010);
    tick();
    expect_out("drop_zero", '0, 1'b1, 4'b0000);
    tick();
    expect_out("drop_d3", DW'('hD3), 1'b0, 4'b1000);
    tick();
    expect_idle("drop_end");
    $display("txn drop-insertion complete");

    // Backpressure
    out_ready = 1'b0;
    dispatch(0, 1'b0);
    dispatch(1, 1'b0);
    dispatch(2, 1'b0);
    set_desc(0, DW'('hE0));
    set_desc(1, DW'('hE1));
    set_desc(2, DW'('hE2));
    eng_done = 4'b0111;
    tick();
    eng_done = '0;
    tick();
    expect_out("bp_first", DW'('hE0), 1'b0, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("bp_stall", DW'('hE0), 1'b0, 4'b0000);
    end
    out_ready = 1'b1;
    tick();
    expect_out("bp_e1", DW'('hE1), 1'b0, 4'b0010);
    tick();
    expect_out("bp_e2", DW'('hE2), 1'b0, 4'b0100);
    tick();
    expect_idle("bp_end");
    $display("txn backpressure complete");

    // Overflow: 9 pushes into a depth-8 FIFO with the head stalled
    for (int i = 0; i < 8; i++) begin
      chk("ovf_notfull", DW'(order_full), DW'(0));
      dispatch(i % 4, 1'b0);
    end
    chk("ovf_full", DW'(order_full), DW'(1));
    chk("ovf_err_pre", DW'(err_overflow), DW'(0));
    dispatch(0, 1'b0);
    chk("ovf_err", DW'(err_overflow), DW'(1));
    for (int e = 0; e < 4; e++) set_desc(e, DW'('hF0 + e));
    eng_done = 4'b1111;
    tick();
    eng_done = '0;
    tick();
    expect_out("ovf_f0", DW'('hF0), 1'b0, 4'b0001);
    chk("ovf_full_drop", DW'(order_full), DW'(0));
    tick();
    expect_out("ovf_f1", DW'('hF1), 1'b0, 4'b0010);
    tick();
    expect_out("ovf_f2", DW'('hF2), 1'b0, 4'b0100);
    tick();
    expect_out("ovf_f3", DW'('hF3), 1'b0, 4'b1000);
    for (int e = 0; e < 4; e++) set_desc(e, DW'('h60 + e));
    eng_done = 4'b1111;
    tick();
    eng_done = '0;
    expect_idle("ovf_gap");
    tick();
    expect_out("ovf_g0", DW'('h60), 1'b0, 4'b0001);
    tick();
    expect_out("ovf_g1", DW'('h61), 1'b0, 4'b0010);
    tick();
    expect_out("ovf_g2", DW'('h62), 1'b0, 4'b0100);
    tick();
    expect_out("ovf_g3", DW'('h63), 1'b0, 4'b1000);
    tick();
    expect_idle("ovf_ninth_discarded");
    tick();
    expect_idle("ovf_end");
    chk("ovf_err_sticky", DW'(err_overflow), DW'(1));
    $display("txn overflow complete");

    // Reset mid-operation
    out_ready = 1'b0;
    dispatch(0, 1'b0);
    dispatch(1, 1'b0);
    dispatch(2, 1'b0);
    set_desc(0, DW'('h70));
    set_desc(1, DW'('h71));
    set_desc(2, DW'('h72));
    eng_done = 4'b0111;
    tick();
    eng_done = '0;
    tick();
    expect_out("mid_pre", DW'('h70), 1'b0, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", DW'(out_valid), DW'(0));
    chk("mid_desc", out_desc, '0);
    chk("mid_release", DW'(eng_release), DW'(0));
    chk("mid_err", DW'(err_overflow), DW'(0));
    chk("mid_full", DW'(order_full), DW'(0));
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    expect_idle("post_idle");
    dispatch(3, 1'b0);
    set_desc(3, DW'('h88));
    eng_done = 4'b1000;
    tick();
    eng_done = '0;
    expect_idle("post_wait");
    tick();
    expect_out("post_e3", DW'('h88), 1'b0, 4'b1000);
    tick();
    expect_idle("post_end");
    chk("post_err", DW'(err_overflow), DW'(0));
    $display("txn reset-recovery complete");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
